// File: rtl/basic_comp_pkg.sv
// Shared constants for the basic-computer memory fetch path: widths, opcodes, FSM encoding.
package basic_comp_pkg;

  localparam int BC_AW = 12;
  localparam int BC_DW = 16;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_LDA = 3'd2;
  localparam logic [2:0] OP_STA = 3'd3;
  localparam logic [2:0] OP_BUN = 3'd4;
  localparam logic [2:0] OP_BSA = 3'd5;
  localparam logic [2:0] OP_ISZ = 3'd6;
  localparam logic [2:0] OP_REG = 3'd7;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_FETCH  = 3'd1;
  localparam state_t ST_INDIR  = 3'd2;
  localparam state_t ST_ACCESS = 3'd3;
  localparam state_t ST_RESP   = 3'd4;

  // Memory-reference opcodes that touch M[EA] after address resolution.
  function automatic logic needs_access(input logic [2:0] op);
    return (op == OP_AND) || (op == OP_ADD) || (op == OP_LDA) ||
           (op == OP_STA) || (op == OP_ISZ);
  endfunction

endpackage

// File: rtl/mem_fetch_unit.sv
// Memory-port initiator: fetches IR at PC, resolves direct/indirect EA, then reads
// the operand or stores the supplied word, and hands the result over valid/ready.
//
//  state  | meaning
//  IDLE   | req_ready=1, waiting for a request
//  FETCH  | mem_addr=PC, capture IR and direct EA
//  INDIR  | mem_addr=EA, replace EA with pointer word
//  ACCESS | mem_addr=EA, read operand or write STA data
//  RESP   | rsp_valid=1, hold until rsp_ready
module mem_fetch_unit
  import basic_comp_pkg::*;
#(
  parameter int AW = BC_AW,
  parameter int DW = BC_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_pc,
  input  logic [DW-1:0] req_data,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_ir,
  output logic [AW-1:0] rsp_ea,
  output logic [DW-1:0] rsp_operand,
  output logic          rsp_indirect,
  output logic [AW-1:0] mem_addr,
  output logic          mem_write,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  state_t        state;
  logic [AW-1:0] pc_q;
  logic [AW-1:0] ea_q;
  logic [DW-1:0] data_q;
  logic [DW-1:0] ir_q;
  logic [DW-1:0] operand_q;
  logic [2:0]    ir_op;
  logic [2:0]    fetch_op;

  assign ir_op    = ir_q[14:12];
  assign fetch_op = mem_rdata[14:12];

  function automatic state_t route(input logic [2:0] op);
    return needs_access(op) ? ST_ACCESS : ST_RESP;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      pc_q      <= '0;
      ea_q      <= '0;
      data_q    <= '0;
      ir_q      <= '0;
      operand_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            pc_q      <= req_pc;
            data_q    <= req_data;
            operand_q <= '0;
            state     <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          ir_q <= mem_rdata;
          ea_q <= mem_rdata[AW-1:0];
          // Register-reference/IO words carry no address; the I bit means nothing there.
          if (fetch_op == OP_REG)
            state <= ST_RESP;
          else if (mem_rdata[DW-1])
            state <= ST_INDIR;
          else
            state <= route(fetch_op);
        end
        ST_INDIR: begin
          ea_q  <= mem_rdata[AW-1:0];
          state <= route(ir_op);
        end
        ST_ACCESS: begin
          if (ir_op != OP_STA)
            operand_q <= mem_rdata;
          state <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_addr = '0;
    case (state)
      ST_FETCH:            mem_addr = pc_q;
      ST_INDIR, ST_ACCESS: mem_addr = ea_q;
      default:             mem_addr = '0;
    endcase
  end

  assign mem_write    = (state == ST_ACCESS) && (ir_op == OP_STA);
  assign mem_wdata    = mem_write ? data_q : '0;
  assign req_ready    = (state == ST_IDLE);
  assign rsp_valid    = (state == ST_RESP);
  assign rsp_ir       = ir_q;
  assign rsp_ea       = ea_q;
  assign rsp_operand  = operand_q;
  assign rsp_indirect = ir_q[DW-1] && (ir_op != OP_REG);

endmodule
